serial_ad_capture: RTL and testbench
====================================

Name: serial_ad_capture

Overview:
- Single-clock serial ADC front end feeding the PCM/Hamming path.
- Consumes the enable ticks produced by the multi-rate divider stage: a serial-bit half-period tick and a sample-rate frame tick. It does not consume the divided clocks.
- Drives the ADC chip-select and serial clock, shifts in one frame per frame tick, and presents a parallel sample with a one-cycle valid pulse.
- Checks the ADC's leading-zero bits and flags frame overruns.

Parameters:
- DATA_W, 12, sample width in bits, captured MSB first.
- LEAD_BITS, 2, leading bits before the data that the ADC must drive as 0.
- FRAME_BITS, 14, total SCLK periods per frame. Must equal LEAD_BITS+DATA_W.
- QUIET_TICKS, 1, sclk_tick count with ad_cs_n high after a frame before IDLE.

Ports:
- clkIn  in  1  system clock, ~31.25 MHz; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  capture enable; sampled in IDLE only.
- sclk_tick  in  1  one-clkIn-cycle pulse, one per SCLK half-period.
- frame_tick  in  1  one-clkIn-cycle pulse, one per sample period.
- ad_sdata  in  1  ADC serial data out, pre-synchronised upstream.
- overrun_clr  in  1  clears the overrun flag.
- ad_cs_n  out  1  ADC chip select, active low.
- ad_sclk  out  1  ADC serial clock; idles high.
- sample  out  DATA_W  last captured sample.
- sample_valid  out  1  one-cycle pulse when sample updates.
- sample_err  out  1  lead-bit error for the current sample; qualified by sample_valid, held with sample.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky flag: frame_tick arrived while busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - ad_cs_n=1, ad_sclk=1, sample=0, sample_valid=0, sample_err=0, busy=0, overrun=0.
  - Bit and tick counters=0; shift register=0.
  - Mid-frame reset aborts the frame immediately; no partial sample is produced.
- States: IDLE, SETUP, SHIFT, QUIET.
- IDLE:
  - On frame_tick=1 with en=1: go to SETUP, ad_cs_n<=0, busy<=1.
  - frame_tick with en=0 is ignored.
  - A sclk_tick in the same cycle as the start is not consumed.
- SETUP:
  - On the next sclk_tick: go to SHIFT and clear the half-period counter. ad_sclk stays 1.
- SHIFT:
  - Each sclk_tick toggles ad_sclk. This gives 2*FRAME_BITS ticks.
  - Odd ticks (1, 3, …) drive ad_sclk 1→0; the ADC launches a bit.
  - Even ticks drive ad_sclk 0→1. ad_sdata is captured in that same clkIn cycle and shifted in at the LSB.
  - Bits 0..LEAD_BITS-1 are lead bits. Any lead bit equal to 1 sets an internal err flag, cleared at SETUP entry.
  - Remaining bits form sample data, MSB first.
  - On the final even tick (tick 2*FRAME_BITS): ad_sclk=1, ad_cs_n<=1, go to QUIET.
  - In the following clkIn cycle: sample<=shift[DATA_W-1:0], sample_err<=err, sample_valid=1 for exactly one cycle.
  - Latency: last rising ad_sclk to sample_valid is 1 clkIn cycle.
- QUIET:
  - Count QUIET_TICKS sclk_ticks, then go to IDLE and set busy<=0.
  - If QUIET_TICKS=0, go straight to IDLE after the output cycle.
- Overrun:
  - frame_tick in SETUP, SHIFT or QUIET sets overrun=1. The tick is dropped and the frame in progress is unaffected.
  - overrun_clr=1 clears overrun.
  - If overrun_clr and a new overrun event occur in the same cycle, overrun stays 1 (set wins).
- en deasserted mid-frame: the current frame completes normally.
- Timing constraint, integrator responsibility: the frame_tick period must be at least (1+2*FRAME_BITS+QUIET_TICKS) sclk_tick periods plus 2 cycles. Otherwise overrun is raised every frame.
- Widths:
  - Half-period counter is ceil(log2(2*FRAME_BITS+1)) bits.
  - Shift register is FRAME_BITS bits; the lead bits fall out of the DATA_W slice.
  - Counters never wrap within a frame.

Test Plan:
- Reset, then release. Drive sclk_tick every 4 cycles and frame_tick once; ADC model returns 00 + 12'hA5C.
  -> ad_cs_n low for the frame, exactly 14 rising ad_sclk edges, sample=12'hA5C, sample_err=0, one sample_valid pulse.
- ADC model drives lead bits 01, data 12'h001.
  -> sample=12'h001, sample_err=1.
- Second frame_tick during SHIFT.
  -> overrun=1, the first sample completes correctly, no second frame.
- overrun_clr pulse coinciding with another overrun-causing frame_tick.
  -> overrun remains 1. overrun_clr alone on a later cycle -> overrun=0.
- Assert reset at half-period tick 15 of SHIFT.
  -> outputs return to their reset values in the same cycle without waiting for a clock edge; no sample_valid. The next frame captures 12'h7FF correctly.
- en=0 with frame_ticks present.
  -> ad_cs_n stays 1, busy=0, overrun=0. Raising en lets the next frame_tick start normally.

Source files
------------

// File: rtl/serial_ad_capture.sv
// Serial ADC front end: drives CS/SCLK from an external half-period tick, shifts in one
// frame per frame tick, checks the leading-zero bits and presents a parallel sample.
module serial_ad_capture #(
   parameter int DATA_W      = 12,
   parameter int LEAD_BITS   = 2,
   parameter int FRAME_BITS  = 14,
   parameter int QUIET_TICKS = 1
) (
   input  logic              clkIn,
   input  logic              reset,
   input  logic              en,
   input  logic              sclk_tick,
   input  logic              frame_tick,
   input  logic              ad_sdata,
   input  logic              overrun_clr,
   output logic              ad_cs_n,
   output logic              ad_sclk,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              sample_err,
   output logic              busy,
   output logic              overrun
);

   localparam int HALF_W = $clog2(2*FRAME_BITS+1);
   localparam int QCNT_W = (QUIET_TICKS > 0) ? $clog2(QUIET_TICKS+1) : 1;
   localparam logic [HALF_W-1:0] LAST_TICK = HALF_W'(2*FRAME_BITS);
   localparam logic [HALF_W-1:0] LEAD_LAST = HALF_W'(2*LEAD_BITS);
   localparam logic [QCNT_W-1:0] QUIET_MAX = QCNT_W'(QUIET_TICKS);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

   state_t                state_q, state_d;
   logic                  ad_cs_n_q, ad_cs_n_d;
   logic                  ad_sclk_q, ad_sclk_d;
   logic [DATA_W-1:0]     sample_q, sample_d;
   logic                  sample_valid_q, sample_valid_d;
   logic                  sample_err_q, sample_err_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;
   logic [HALF_W-1:0]     half_q, half_d;
   logic [QCNT_W-1:0]     quiet_q, quiet_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  err_q, err_d;
   logic                  pend_q, pend_d;

   logic [HALF_W-1:0]     half_next;
   logic [QCNT_W-1:0]     quiet_next;

   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         ad_cs_n_q      <= 1'b1;
         ad_sclk_q      <= 1'b1;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         sample_err_q   <= 1'b0;
         busy_q         <= 1'b0;
         overrun_q      <= 1'b0;
         half_q         <= '0;
         quiet_q        <= '0;
         shift_q        <= '0;
         err_q          <= 1'b0;
         pend_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         ad_cs_n_q      <= ad_cs_n_d;
         ad_sclk_q      <= ad_sclk_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         sample_err_q   <= sample_err_d;
         busy_q         <= busy_d;
         overrun_q      <= overrun_d;
         half_q         <= half_d;
         quiet_q        <= quiet_d;
         shift_q        <= shift_d;
         err_q          <= err_d;
         pend_q         <= pend_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      ad_cs_n_d      = ad_cs_n_q;
      ad_sclk_d      = ad_sclk_q;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      sample_err_d   = sample_err_q;
      busy_d         = busy_q;
      overrun_d      = overrun_q;
      half_d         = half_q;
      quiet_d        = quiet_q;
      shift_d        = shift_q;
      err_d          = err_q;
      pend_d         = 1'b0;
      half_next      = half_q + 1'b1;
      quiet_next     = quiet_q;

      // Output cycle: one clock after the final rising SCLK edge.
      if (pend_q) begin
         sample_d       = shift_q[DATA_W-1:0];
         sample_err_d   = err_q;
         sample_valid_d = 1'b1;
      end

      if (overrun_clr)
         overrun_d = 1'b0;
      if (frame_tick && state_q != IDLE)
         overrun_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (frame_tick && en) begin
               state_d   = SETUP;
               ad_cs_n_d = 1'b0;
               busy_d    = 1'b1;
               err_d     = 1'b0;
               shift_d   = '0;
            end
         end
         SETUP: begin
            if (sclk_tick) begin
               state_d = SHIFT;
               half_d  = '0;
            end
         end
         SHIFT: begin
            if (sclk_tick) begin
               half_d    = half_next;
               ad_sclk_d = ~ad_sclk_q;
               // Even ticks are rising SCLK edges: capture the bit launched on the fall.
               if (!half_next[0]) begin
                  shift_d = {shift_q[FRAME_BITS-2:0], ad_sdata};
                  if (half_next <= LEAD_LAST && ad_sdata)
                     err_d = 1'b1;
               end
               if (half_next == LAST_TICK) begin
                  ad_sclk_d = 1'b1;
                  ad_cs_n_d = 1'b1;
                  state_d   = QUIET;
                  quiet_d   = '0;
                  pend_d    = 1'b1;
               end
            end
         end
         QUIET: begin
            if (sclk_tick && quiet_q != QUIET_MAX)
               quiet_next = quiet_q + 1'b1;
            quiet_d = quiet_next;
            if (quiet_next == QUIET_MAX) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ad_cs_n      = ad_cs_n_q;
   assign ad_sclk      = ad_sclk_q;
   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign sample_err   = sample_err_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_serial_ad_capture.sv
// Scoreboard bench for serial_ad_capture: an ADC model answers SCLK falls, expected
// samples are queued at frame start and a monitor checks each sample_valid pulse.
module tb_serial_ad_capture;

   logic        clkIn = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        sclk_tick = 1'b0;
   logic        frame_tick = 1'b0;
   logic        ad_sdata = 1'b0;
   logic        overrun_clr = 1'b0;
   logic        ad_cs_n;
   logic        ad_sclk;
   logic [11:0] sample;
   logic        sample_valid;
   logic        sample_err;
   logic        busy;
   logic        overrun;

   serial_ad_capture dut (
      .clkIn(clkIn), .reset(reset), .en(en), .sclk_tick(sclk_tick),
      .frame_tick(frame_tick), .ad_sdata(ad_sdata), .overrun_clr(overrun_clr),
      .ad_cs_n(ad_cs_n), .ad_sclk(ad_sclk), .sample(sample),
      .sample_valid(sample_valid), .sample_err(sample_err), .busy(busy),
      .overrun(overrun)
   );

   always #5 clkIn = ~clkIn;

   typedef struct packed {
      logic [11:0] data;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [13:0] adc_word = '0;
   int          adc_idx = 0;
   int          rises = 0;
   int          falls = 0;
   logic        prev_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Half-period tick every 4 clocks, driven on the falling edge.
   initial begin
      int div = 0;
      forever begin
         @(negedge clkIn);
         sclk_tick = (div == 3);
         div = (div + 1) % 4;
      end
   end

   // ADC model: frame starts at CS fall, each SCLK fall launches the next bit MSB first.
   always @(negedge ad_cs_n) begin
      adc_idx = 0;
      rises = 0;
      falls = 0;
   end
   always @(negedge ad_sclk) begin
      if (!ad_cs_n && adc_idx < 14) begin
         ad_sdata = adc_word[13 - adc_idx];
         adc_idx++;
      end
      falls++;
   end
   always @(posedge ad_sclk) rises++;

   // Monitor: pop one expectation per sample_valid pulse.
   always @(negedge clkIn) begin
      if (sample_valid) begin
         if (prev_valid) chk("valid_width", 32'd2, 32'd1);
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", {20'd0, sample}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("sample=%03h err=%0b (expect %03h/%0b) rises=%0d",
                     sample, sample_err, e.data, e.err, rises);
            chk("sample", {20'd0, sample}, {20'd0, e.data});
            chk("sample_err", {31'd0, sample_err}, {31'd0, e.err});
            chk("sclk_rises", rises, 32'd14);
            chk("cs_at_valid", {31'd0, ad_cs_n}, 32'd1);
         end
      end
      prev_valid = sample_valid;
   end

   task automatic pulse_frame(input logic clr);
      @(negedge clkIn);
      frame_tick = 1'b1;
      overrun_clr = clr;
      @(negedge clkIn);
      frame_tick = 1'b0;
      overrun_clr = 1'b0;
   endtask

   task automatic start_frame(input logic [13:0] word, input logic expect_out);
      exp_t e;
      adc_word = word;
      if (expect_out) begin
         e.data = word[11:0];
         e.err  = |word[13:12];
         exp_q.push_back(e);
      end
      pulse_frame(1'b0);
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_cs", {31'd0, ad_cs_n}, 32'd0);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clkIn);
         n++;
      end
      chk(name, {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clkIn);
      chk({name, "_drained"}, exp_q.size(), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cs"}, {31'd0, ad_cs_n}, 32'd1);
      chk({tag, "_sclk"}, {31'd0, ad_sclk}, 32'd1);
      chk({tag, "_sample"}, {20'd0, sample}, 32'd0);
      chk({tag, "_valid"}, {31'd0, sample_valid}, 32'd0);
      chk({tag, "_err"}, {31'd0, sample_err}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clkIn);
      chk_reset_outputs("rst");
      reset = 1'b1;
      en = 1'b1;
      repeat (5) @(negedge clkIn);

      // Clean frame and a lead-bit error frame.
      start_frame({2'b00, 12'hA5C}, 1'b1);
      wait_idle("f1_idle");
      chk("f1_hold", {20'd0, sample}, 32'hA5C);
      start_frame({2'b01, 12'h001}, 1'b1);
      wait_idle("f2_idle");

      // Second frame_tick mid-SHIFT: overrun, frame unaffected, no extra frame.
      start_frame({2'b00, 12'h3C3}, 1'b1);
      repeat (40) @(negedge clkIn);
      pulse_frame(1'b0);
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      wait_idle("f3_idle");
      repeat (20) @(negedge clkIn);
      chk("no_second_frame", {31'd0, busy}, 32'd0);

      // Clear coinciding with a new overrun event: set wins; then plain clear.
      start_frame({2'b00, 12'h155}, 1'b1);
      repeat (30) @(negedge clkIn);
      pulse_frame(1'b1);
      chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
      wait_idle("f4_idle");
      @(negedge clkIn);
      overrun_clr = 1'b1;
      @(negedge clkIn);
      overrun_clr = 1'b0;
      chk("ovr_cleared", {31'd0, overrun}, 32'd0);

      // Asynchronous reset at half-period tick 15 (8th SCLK fall) of SHIFT.
      start_frame({2'b00, 12'h800}, 1'b0);
      begin
         int n = 0;
         while (falls < 8 && n < 200) begin
            @(posedge clkIn);
            n++;
         end
         chk("reach_tick15", falls, 32'd8);
      end
      #2 reset = 1'b0;
      #1 chk_reset_outputs("midrst");
      repeat (4) @(negedge clkIn);
      reset = 1'b1;
      repeat (3) @(negedge clkIn);
      start_frame({2'b00, 12'h7FF}, 1'b1);
      wait_idle("f5_idle");

      // en low: frame ticks ignored.
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pulse_frame(1'b0);
         chk("en0_cs", {31'd0, ad_cs_n}, 32'd1);
         chk("en0_busy", {31'd0, busy}, 32'd0);
         chk("en0_ovr", {31'd0, overrun}, 32'd0);
         repeat (10) @(negedge clkIn);
      end
      en = 1'b1;
      start_frame({2'b00, 12'h0F0}, 1'b1);
      wait_idle("f6_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timeout");
      $fatal(1, "timeout");
   end

endmodule
